// File: rtl/sort_pkg.sv
// sort_pkg: shared class codes, FIFO entry layout and helpers for the sort actuator.
//   CLS_NONE/CLS_SMALL/CLS_LARGE/CLS_INV : classifier codes on class_in
//   sort_entry_t                         : {class, arrival stamp} at the default 16-bit stamp width
package sort_pkg;

    typedef logic [1:0] cls_t;

    localparam cls_t CLS_NONE  = 2'b00;
    localparam cls_t CLS_SMALL = 2'b01;
    localparam cls_t CLS_LARGE = 2'b10;
    localparam cls_t CLS_INV   = 2'b11;

    localparam int SORT_TS_W = 16;

    typedef struct packed {
        cls_t                 cls;
        logic [SORT_TS_W-1:0] stamp;
    } sort_entry_t;

    function automatic logic is_obj(input cls_t c);
        return (c == CLS_SMALL) || (c == CLS_LARGE);
    endfunction

endpackage

// File: rtl/sort_fifo.sv
// sort_fifo: synchronous FIFO with head read-ahead for in-flight sort events.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push_i     : write din_i; accepted when not full, or when full with a pop in the same edge
//   pop_i      : drop the head; ignored when empty
//   dout_o     : current head entry (valid while !empty_o)
//   full_o, empty_o, count_o : occupancy status
module sort_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 18
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/sort_actuator.sv
// sort_actuator: delays classifier events by DELAY cycles, then drives the matching actuator for HOLD cycles.
//   clk, rst_n            : clock, asynchronous active-low reset
//   class_in              : 00 idle, 01 small, 10 large, 11 invalid (sets err)
//   act_small, act_large  : actuator drives, independent, may overlap
//   busy                  : events in flight or any actuator active
//   ovf, err              : sticky drop / invalid-code flags
//   cnt_small/large/drop  : saturating statistics, only built with SORT_STATS_EN defined (else tied 0)
module sort_actuator
    import sort_pkg::*;
#(
    parameter int DELAY = 1000,
    parameter int HOLD  = 50,
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       class_in,
    output logic             act_small,
    output logic             act_large,
    output logic             busy,
    output logic             ovf,
    output logic             err,
    output logic [CNT_W-1:0] cnt_small,
    output logic [CNT_W-1:0] cnt_large,
    output logic [CNT_W-1:0] cnt_drop
);
    localparam int HW = $clog2(HOLD + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        cls_t            cls;
        logic [TS_W-1:0] stamp;
    } entry_t;

    logic [TS_W-1:0] ts_q;
    entry_t          head, din;
    logic            full, empty;
    logic [CW-1:0]   count, count_d;
    logic [HW-1:0]   hs_q, hs_d, hl_q, hl_d;
    logic            busy_q, busy_d, ovf_q, err_q;
    logic            valid, fire, push, drop;

    assign valid = is_obj(class_in);
    // Modular age makes timestamp wrap transparent; only the head can be due since delay is constant.
    assign fire  = ~empty & ((ts_q - head.stamp) == TS_W'(DELAY));
    assign push  = valid & (~full | fire);
    assign drop  = valid & full & ~fire;
    assign din   = '{cls: class_in, stamp: ts_q};

    sort_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (fire),
        .din_i   (din),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        hs_d    = (fire && head.cls == CLS_SMALL) ? HW'(HOLD) : hs_q - HW'(hs_q != '0);
        hl_d    = (fire && head.cls == CLS_LARGE) ? HW'(HOLD) : hl_q - HW'(hl_q != '0);
        count_d = count + CW'(push) - CW'(fire);
        busy_d  = (count_d != '0) | (hs_d != '0) | (hl_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q   <= '0;
            hs_q   <= '0;
            hl_q   <= '0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ts_q   <= ts_q + TS_W'(1);
            hs_q   <= hs_d;
            hl_q   <= hl_d;
            busy_q <= busy_d;
            ovf_q  <= ovf_q | drop;
            err_q  <= err_q | (class_in == CLS_INV);
        end
    end

    assign act_small = (hs_q != '0);
    assign act_large = (hl_q != '0);
    assign busy      = busy_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

`ifdef SORT_STATS_EN
    logic [CNT_W-1:0] cs_q, cl_q, cd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q <= '0;
            cl_q <= '0;
            cd_q <= '0;
        end else begin
            if (push && class_in == CLS_SMALL && ~&cs_q) cs_q <= cs_q + CNT_W'(1);
            if (push && class_in == CLS_LARGE && ~&cl_q) cl_q <= cl_q + CNT_W'(1);
            if (drop && ~&cd_q) cd_q <= cd_q + CNT_W'(1);
        end
    end

    assign cnt_small = cs_q;
    assign cnt_large = cl_q;
    assign cnt_drop  = cd_q;
`else
    assign cnt_small = '0;
    assign cnt_large = '0;
    assign cnt_drop  = '0;
`endif

endmodule

// File: tb/tb_sort_actuator.sv
// tb_sort_actuator: scenario tasks checked each cycle against an event-queue model in absolute cycle time.
module tb_sort_actuator;
    localparam int D   = 20;
    localparam int H   = 5;
    localparam int DP  = 4;
    localparam int TW  = 8;
    localparam int CW  = 3;
    localparam int SAT = (1 << CW) - 1;
`ifdef SORT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    class_in = 2'b00;
    logic          act_small, act_large, busy, ovf, err;
    logic [CW-1:0] cnt_small, cnt_large, cnt_drop;

    int n_cmp = 0;
    int n_bad = 0;

    sort_actuator #(.DELAY(D), .HOLD(H), .DEPTH(DP), .TS_W(TW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .class_in  (class_in),
        .act_small (act_small),
        .act_large (act_large),
        .busy      (busy),
        .ovf       (ovf),
        .err       (err),
        .cnt_small (cnt_small),
        .cnt_large (cnt_large),
        .cnt_drop  (cnt_drop)
    );

    always #5 clk = ~clk;

    // Model: events carry an absolute due cycle; actuator is on while the cycle is before its "until" mark.
    typedef struct {
        logic [1:0] c;
        int         due;
    } ev_t;
    ev_t q[$];
    int  t, us, ul, m_cs, m_cl, m_cd;
    bit  m_err, m_ovf, e_s, e_l;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            t = 0; us = -1; ul = -1;
            m_cs = 0; m_cl = 0; m_cd = 0;
            m_err = 0; m_ovf = 0; e_s = 0; e_l = 0;
        end else begin
            if (q.size() != 0 && q[0].due == t) begin
                if (q[0].c == 2'b01) us = t + H;
                else ul = t + H;
                void'(q.pop_front());
            end
            if (class_in == 2'b01 || class_in == 2'b10) begin
                if (q.size() < DP) begin
                    q.push_back('{c: class_in, due: t + D});
                    if (class_in == 2'b01) m_cs = (m_cs < SAT) ? m_cs + 1 : SAT;
                    else m_cl = (m_cl < SAT) ? m_cl + 1 : SAT;
                end else begin
                    m_ovf = 1;
                    m_cd = (m_cd < SAT) ? m_cd + 1 : SAT;
                end
            end else if (class_in == 2'b11) m_err = 1;
            e_s = t < us;
            e_l = t < ul;
            t++;
        end
    end

    function automatic logic [4:0] exp_v();
        return {e_s, e_l, (q.size() != 0) || e_s || e_l, m_ovf, m_err};
    endfunction

    function automatic logic [3*CW-1:0] exp_c();
        return STATS ? {CW'(m_cs), CW'(m_cl), CW'(m_cd)} : '0;
    endfunction

    task automatic tick(input logic [1:0] c);
        class_in = c;
        @(posedge clk);
        #1;
        class_in = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({act_small, act_large, busy, ovf, err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000", {act_small, act_large, busy, ovf, err});
        end
        n_cmp++;
        if ({cnt_small, cnt_large, cnt_drop} !== '0) begin
            n_bad++;
            $display("FAIL reset_cnt: got %h want 0", {cnt_small, cnt_large, cnt_drop});
        end
    endtask

    task automatic test_single();
        int nh = 0;
        do_reset();
        repeat (10) tick(2'b00);
        tick(2'b01);
        for (int i = 1; i <= 30; i++) begin
            tick(2'b00);
            nh += int'(act_small);
            n_cmp++;
            if ({act_small, act_large, busy, ovf, err} !== exp_v()) begin
                n_bad++;
                $display("FAIL single c%0d: got %b want %b", i, {act_small, act_large, busy, ovf, err}, exp_v());
            end
        end
        n_cmp++;
        if (nh !== H) begin
            n_bad++;
            $display("FAIL single_width: got %0d want %0d", nh, H);
        end
        n_cmp++;
        if ({cnt_small, cnt_large, cnt_drop} !== exp_c()) begin
            n_bad++;
            $display("FAIL single_cnt: got %h want %h", {cnt_small, cnt_large, cnt_drop}, exp_c());
        end
    endtask

    task automatic test_overlap();
        int ov = 0;
        do_reset();
        repeat (10) tick(2'b00);
        tick(2'b01);
        tick(2'b00);
        tick(2'b10);
        for (int i = 1; i <= 30; i++) begin
            tick(2'b00);
            ov += int'(act_small & act_large);
            n_cmp++;
            if ({act_small, act_large, busy, ovf, err} !== exp_v()) begin
                n_bad++;
                $display("FAIL overlap c%0d: got %b want %b", i, {act_small, act_large, busy, ovf, err}, exp_v());
            end
        end
        n_cmp++;
        if (ov !== H - 2) begin
            n_bad++;
            $display("FAIL overlap_both: got %0d want %0d", ov, H - 2);
        end
    endtask

    task automatic test_reload();
        int nh = 0;
        int rises = 0;
        logic prev = 1'b0;
        do_reset();
        repeat (10) tick(2'b00);
        tick(2'b01);
        repeat (2) tick(2'b00);
        tick(2'b01);
        for (int i = 1; i <= 35; i++) begin
            tick(2'b00);
            nh += int'(act_small);
            rises += int'(act_small & ~prev);
            prev = act_small;
            n_cmp++;
            if ({act_small, act_large, busy, ovf, err} !== exp_v()) begin
                n_bad++;
                $display("FAIL reload c%0d: got %b want %b", i, {act_small, act_large, busy, ovf, err}, exp_v());
            end
        end
        n_cmp++;
        if (nh !== H + 3 || rises !== 1) begin
            n_bad++;
            $display("FAIL reload_pulse: got width %0d rises %0d want width %0d rises 1", nh, rises, H + 3);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 6; i++) tick(i[0] ? 2'b10 : 2'b01);
        for (int i = 1; i <= 30; i++) begin
            tick(2'b00);
            n_cmp++;
            if ({act_small, act_large, busy, ovf, err} !== exp_v()) begin
                n_bad++;
                $display("FAIL overflow c%0d: got %b want %b", i, {act_small, act_large, busy, ovf, err}, exp_v());
            end
        end
        n_cmp++;
        if (ovf !== 1'b1 || cnt_drop !== (STATS ? CW'(2) : CW'(0))) begin
            n_bad++;
            $display("FAIL overflow_drop: got ovf %b drop %0d want ovf 1 drop %0d", ovf, cnt_drop, STATS ? 2 : 0);
        end
    endtask

    task automatic test_err();
        do_reset();
        tick(2'b11);
        for (int i = 1; i <= 30; i++) begin
            tick(2'b00);
            n_cmp++;
            if ({act_small, act_large, busy, ovf, err} !== 5'b00001) begin
                n_bad++;
                $display("FAIL err c%0d: got %b want 00001", i, {act_small, act_large, busy, ovf, err});
            end
        end
    endtask

    task automatic test_wrap();
        int first = -1;
        do_reset();
        repeat (250) tick(2'b00);
        tick(2'b10);
        for (int i = 1; i <= 30; i++) begin
            tick(2'b00);
            if (act_large && first < 0) first = i;
            n_cmp++;
            if ({act_small, act_large, busy, ovf, err} !== exp_v()) begin
                n_bad++;
                $display("FAIL wrap c%0d: got %b want %b", i, {act_small, act_large, busy, ovf, err}, exp_v());
            end
        end
        n_cmp++;
        if (first !== D) begin
            n_bad++;
            $display("FAIL wrap_latency: got %0d want %0d", first, D);
        end
    endtask

    task automatic test_midreset();
        do_reset();
        repeat (10) tick(2'b00);
        tick(2'b01);
        tick(2'b00);
        tick(2'b10);
        repeat (25) tick(2'b00);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({act_small, act_large, busy, cnt_small, cnt_large, cnt_drop} !== '0) begin
            n_bad++;
            $display("FAIL midreset_now: got %b%b%b cnt %h want all 0", act_small, act_large, busy, {cnt_small, cnt_large, cnt_drop});
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick(2'b00);
            n_cmp++;
            if ({act_small, act_large, busy, ovf, err} !== 5'b0) begin
                n_bad++;
                $display("FAIL midreset c%0d: got %b want 00000", i, {act_small, act_large, busy, ovf, err});
            end
        end
    endtask

    task automatic test_random();
        int r;
        logic [1:0] c;
        do_reset();
        for (int i = 1; i <= 700; i++) begin
            r = $urandom_range(0, 9);
            c = (r == 6 || r == 7) ? 2'b01 : (r == 8) ? 2'b10 :
                (r == 9 && $urandom_range(0, 29) == 0) ? 2'b11 : 2'b00;
            tick(c);
            n_cmp++;
            if ({act_small, act_large, busy, ovf, err} !== exp_v() ||
                {cnt_small, cnt_large, cnt_drop} !== exp_c()) begin
                n_bad++;
                $display("FAIL random c%0d: got %b cnt %h want %b cnt %h", i,
                         {act_small, act_large, busy, ovf, err}, {cnt_small, cnt_large, cnt_drop}, exp_v(), exp_c());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overlap();
        test_reload();
        test_overflow();
        test_err();
        test_wrap();
        test_midreset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
